// File: rtl/dlx_mem_responder.sv
// Word-organised RAM responder for the multicycle DLX datapath: programmable wait states, one-cycle MemReady.
// Optional build macro DLX_MEM_MISALIGN_TRAP_EN rejects requests whose Address[1:0] is non-zero.
module dlx_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [31:0]           Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  MemReady,
  output logic                  MemBusy,
  output logic                  AddrError
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    we_q, we_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    req, reject, load_rd;
  logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];
  logic                    unused_addr;

  assign unused_addr = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};

  always_comb begin
    req = MemRead | MemWrite;
`ifdef DLX_MEM_MISALIGN_TRAP_EN
    reject = (MemRead & MemWrite) | (req & (Address[1:0] != 2'b00));
`else
    reject = MemRead & MemWrite;
`endif
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (reject) begin
            err_d = 1'b1;
          end else begin
            addr_d  = Address[ADDR_WIDTH+1:2];
            wdata_d = WriteData;
            we_d    = MemWrite;
            cnt_d   = 4'(WAIT_STATES);
            state_d = (WAIT_STATES == 0) ? DONE : ACCESS;
          end
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Sample the RAM on the edge that enters DONE so ReadData is valid alongside MemReady.
    load_rd = (state_d == DONE) && (state_q != DONE) && !we_d;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
      if (load_rd) rdata_q <= mem[addr_d];
    end
  end

  // An async reset leaves DONE before the edge, so an aborted write never commits.
  always_ff @(posedge Clock) begin
    if (state_q == DONE && we_q) mem[addr_q] <= wdata_q;
  end

  assign ReadData  = rdata_q;
  assign MemReady  = (state_q == DONE);
  assign MemBusy   = (state_q != IDLE);
  assign AddrError = err_q;

endmodule

// File: tb/tb_dlx_mem_responder.sv
// Directed bench for dlx_mem_responder: instance 0 uses two wait states, instance 1 uses zero.
module tb_dlx_mem_responder;

  logic        clk;
  logic        rst  [2];
  logic        rd   [2];
  logic        wr   [2];
  logic [31:0] addr [2];
  logic [31:0] wd   [2];
  logic [31:0] rdata[2];
  logic        rdy  [2];
  logic        busy [2];
  logic        aerr [2];

  int checks   = 0;
  int failures = 0;

  dlx_mem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_STATES(2)) u_ws2 (
    .Clock(clk), .Reset(rst[0]), .MemRead(rd[0]), .MemWrite(wr[0]), .Address(addr[0]),
    .WriteData(wd[0]), .ReadData(rdata[0]), .MemReady(rdy[0]), .MemBusy(busy[0]), .AddrError(aerr[0]));

  dlx_mem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_STATES(0)) u_ws0 (
    .Clock(clk), .Reset(rst[1]), .MemRead(rd[1]), .MemWrite(wr[1]), .Address(addr[1]),
    .WriteData(wd[1]), .ReadData(rdata[1]), .MemReady(rdy[1]), .MemBusy(busy[1]), .AddrError(aerr[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request, then observe eight cycles; index k is the k-th cycle after the accepting edge.
  task automatic access(input int i, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output int rdy_at, output int rdy_n,
                        output int busy_n, output int err_at, output int err_n,
                        output logic [31:0] rv);
    @(negedge clk);
    rd[i] = r; wr[i] = w; addr[i] = a; wd[i] = d;
    @(posedge clk);
    #1;
    rd[i] = 1'b0; wr[i] = 1'b0;
    rdy_at = 0; rdy_n = 0; busy_n = 0; err_at = 0; err_n = 0; rv = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (rdy[i]) begin
        if (rdy_n == 0) begin rdy_at = k; rv = rdata[i]; end
        rdy_n++;
      end
      if (busy[i]) busy_n++;
      if (aerr[i]) begin
        if (err_n == 0) err_at = k;
        err_n++;
      end
    end
  endtask

  initial begin
    int          ra, rn, bn, ea, en;
    logic [31:0] v;
    logic [7:0]  pat;

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wd[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy",  32'(busy[0]), 32'd0);
    check("reset_ready", 32'(rdy[0]),  32'd0);
    check("reset_err",   32'(aerr[0]), 32'd0);
    check("reset_rdata", rdata[0],     32'd0);
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Two wait states: write then read back.
    access(0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, ra, rn, bn, ea, en, v);
    check("ws2_wr_busy_cycles", 32'(bn), 32'd3);
    check("ws2_wr_ready_at",    32'(ra), 32'd3);
    check("ws2_wr_ready_count", 32'(rn), 32'd1);
    access(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, ra, rn, bn, ea, en, v);
    check("ws2_rd_ready_at", 32'(ra), 32'd3);
    check("ws2_rd_data",     v,       32'hDEAD_BEEF);

    // Writes leave ReadData alone; high address bits wrap.
    access(0, 1'b0, 1'b1, 32'h0000_0000, 32'hA5A5_A5A5, ra, rn, bn, ea, en, v);
    check("rdata_hold_after_write", rdata[0], 32'hDEAD_BEEF);
    access(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, ra, rn, bn, ea, en, v);
    check("wrap_rd_ready_at", 32'(ra), 32'd3);
    check("wrap_rd_data",     v,       32'hA5A5_A5A5);

    // Simultaneous strobes are rejected.
    access(0, 1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, ra, rn, bn, ea, en, v);
    access(0, 1'b1, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, ra, rn, bn, ea, en, v);
    check("both_err_at",      32'(ea), 32'd1);
    check("both_err_count",   32'(en), 32'd1);
    check("both_ready_count", 32'(rn), 32'd0);
    check("both_busy_cycles", 32'(bn), 32'd0);
    access(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0, ra, rn, bn, ea, en, v);
    check("both_ram_unchanged", v, 32'hCAFE_F00D);

    // Reset two cycles into a write aborts it.
    access(0, 1'b0, 1'b1, 32'h0000_0040, 32'h1111_1111, ra, rn, bn, ea, en, v);
    @(negedge clk);
    wr[0] = 1'b1; addr[0] = 32'h0000_0040; wd[0] = 32'h0000_0055;
    @(posedge clk);
    #1;
    wr[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst[0] = 1'b1;
    #1;
    check("abort_busy",  32'(busy[0]), 32'd0);
    check("abort_ready", 32'(rdy[0]),  32'd0);
    check("abort_err",   32'(aerr[0]), 32'd0);
    check("abort_rdata", rdata[0],     32'd0);
    @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    access(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, ra, rn, bn, ea, en, v);
    check("abort_rd_ready_at", 32'(ra), 32'd3);
    check("abort_old_value",   v,       32'h1111_1111);

    // Zero wait states.
    access(1, 1'b0, 1'b1, 32'h0000_0000, 32'h1234_5678, ra, rn, bn, ea, en, v);
    check("ws0_wr_ready_at",    32'(ra), 32'd1);
    check("ws0_wr_busy_cycles", 32'(bn), 32'd1);
    access(1, 1'b1, 1'b0, 32'h0000_0000, 32'h0, ra, rn, bn, ea, en, v);
    check("ws0_rd_ready_at", 32'(ra), 32'd1);
    check("ws0_rd_data",     v,       32'h1234_5678);

    // Held MemRead: one completion every two cycles.
    @(negedge clk);
    rd[1] = 1'b1; addr[1] = 32'h0000_0000;
    pat = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      pat[k] = rdy[1];
    end
    rd[1] = 1'b0;
    check("ws0_b2b_pattern", 32'(pat), 32'h0000_0055);
    check("ws0_b2b_data",    rdata[1], 32'h1234_5678);

    // Misaligned read of word 1.
    access(1, 1'b0, 1'b1, 32'h0000_0004, 32'h0000_0077, ra, rn, bn, ea, en, v);
    access(1, 1'b1, 1'b0, 32'h0000_0006, 32'h0, ra, rn, bn, ea, en, v);
`ifdef DLX_MEM_MISALIGN_TRAP_EN
    check("misalign_err_at",      32'(ea), 32'd1);
    check("misalign_err_count",   32'(en), 32'd1);
    check("misalign_ready_count", 32'(rn), 32'd0);
`else
    check("misalign_ready_at", 32'(ra), 32'd1);
    check("misalign_data",     v,       32'h0000_0077);
    check("misalign_err_count", 32'(en), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dlx_mem_responder.md
Name: dlx_mem_responder

Overview:
Memory-side responder for the multicycle DLX datapath. It answers the MemRead/MemWrite strobes that the control unit issues in InstrFetch, MemReadAccess and MemWriteAccess. It holds a word-organised RAM and returns data after a programmable number of wait states, with a one-cycle MemReady completion pulse. It sits between the IorD address mux and the IR/MDR registers; MemReady is the stall qualifier for the controller.

Parameters:
ADDR_WIDTH, 10, number of word-address bits; RAM depth = 2**ADDR_WIDTH words
DATA_WIDTH, 32, word width in bits
WAIT_STATES, 2, extra cycles between request acceptance and MemReady (0..15)

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
MemRead  input  1  read request strobe
MemWrite  input  1  write request strobe
Address  input  32  byte address (from IorD mux)
WriteData  input  DATA_WIDTH  store data (B register)
ReadData  output  DATA_WIDTH  read result, valid when MemReady=1
MemReady  output  1  one-cycle completion pulse, read or write
MemBusy  output  1  high while an access is in flight
AddrError  output  1  one-cycle pulse: rejected or faulted request

Behaviour:
- Reset (async, Reset=1):
  - state to IDLE; ReadData=0, MemReady=0, MemBusy=0, AddrError=0; wait counter=0; latched request cleared.
  - RAM contents are not reset.
  - Reset during ACCESS or DONE aborts the access; a pending write is never committed.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - At a rising edge with MemRead|MemWrite=1, latch Address[ADDR_WIDTH+1:2], WriteData and the op.
  - Load counter with WAIT_STATES. Go to ACCESS, or directly to DONE if WAIT_STATES=0.
  - MemRead=1 and MemWrite=1 together: request rejected, AddrError pulses next cycle, stay IDLE, no RAM change.
- ACCESS:
  - MemBusy=1; counter decrements each cycle.
  - Go to DONE when the counter reaches 1, or at once if loaded with 0.
  - New strobes in ACCESS are ignored (not queued).
- DONE:
  - MemBusy=1, MemReady=1 for exactly one cycle.
  - Read: ReadData = RAM[latched word address], registered so it is valid in the MemReady cycle.
  - Write: RAM updated at the end of the DONE cycle.
  - Next state IDLE unconditionally.
  - A strobe still asserted in the DONE cycle is not accepted; it is sampled again in IDLE on the following edge.
- Latency: request sampled at edge N, so MemReady is high in cycle N+1+WAIT_STATES. Back-to-back throughput is one access per WAIT_STATES+2 cycles.
- ReadData holds its last read value until the next read completes; writes do not disturb it.
- Addressing:
  - Address[31:ADDR_WIDTH+2] are ignored, so accesses wrap modulo RAM depth.
  - Address[1:0] are handled per the optional feature.
- Read-after-write to the same word returns the new data (the write commits before any later read can be accepted).

Optional Feature:
DLX_MEM_MISALIGN_TRAP_EN
- Defined:
  - A request with Address[1:0] != 2'b00 is rejected in IDLE: AddrError pulses the next cycle, no access, no MemReady, state stays IDLE.
- Undefined:
  - Address[1:0] are ignored and the access proceeds to the aligned word.
  - AddrError is raised only for the simultaneous-strobe case.

Test Plan:
- Reset with WAIT_STATES=2, then write 0xDEADBEEF to 0x0000_0010 -> MemBusy high 3 cycles, MemReady pulse at cycle N+3; read 0x10 -> ReadData=0xDEADBEEF with MemReady at N+3.
- WAIT_STATES=0: read 0x0 after writing 0x12345678 -> MemReady at N+1, ReadData=0x12345678; back-to-back reads every 2 cycles.
- Write 0xA5A5A5A5 to word 0, then read 0x0000_1000 (ADDR_WIDTH=10) -> wraps to word 0, returns 0xA5A5A5A5.
- MemRead=MemWrite=1 at 0x20 -> AddrError single-cycle pulse, no MemReady, RAM[8] unchanged.
- Assert Reset two cycles into a write of 0x55 to 0x40 -> all outputs 0 immediately; a subsequent read of 0x40 returns the old value.
- With DLX_MEM_MISALIGN_TRAP_EN defined, read 0x0000_0006 -> AddrError pulse, no MemReady. Without it -> MemReady, data of word 0x4.
